lmdpl_dual_rail_decoder_d1: RTL and testbench

//  Receiving end of the first-order LMDPL dual-rail bus. Converts WIDTH precharge/evaluate

---
 rtl/lmdpl_dual_rail_decoder_d1.sv | 218 +++++++++++++++++++++
 tb/tb_lmdpl_dual_rail_decoder_d1.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lmdpl_dual_rail_decoder_d1.sv
// lmdpl_dual_rail_decoder_d1
//   Receiving end of a first-order LMDPL dual-rail bus. Watches WIDTH
//   precharge/evaluate dual-rail bits, detects spacer and codeword completion,
//   flags protocol errors and hands the word on as two registered Boolean
//   shares with a valid/ready handshake.
//
//   Optional feature: define LMDPL_DEC_REFRESH_EN to add the r_fresh port.
//   Both shares are then re-masked with r_fresh at the capture edge, each
//   XOR feeding its own register.
//
//   Share separation: m_in only ever reaches out_s0, d_in only ever reaches
//   out_s1, and the completion/error detector looks at d_in/d_in_bar alone.
module lmdpl_dual_rail_decoder_d1 #(
  parameter int WIDTH   = 4,   // dual-rail bits decoded in parallel (1..32)
  parameter int TIMEOUT = 15   // max partial-codeword cycles in EVAL (1..255)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] m_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] d_in_bar,
`ifdef LMDPL_DEC_REFRESH_EN
  input  logic [WIDTH-1:0] r_fresh,
`endif
  output logic [WIDTH-1:0] out_s0,
  output logic [WIDTH-1:0] out_s1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  input  logic             err_clr
);

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_PRE  = 2'd0,
    ST_EVAL = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [7:0]       timer_inc;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] s0_q, s0_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s0_cap;
  logic [WIDTH-1:0] s1_cap;
  logic             capture_en;
  logic             clear_shares;

  // ---------------------------------------------------------------------
  // Per-bit rail classification (data rails only, never the mask rail)
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] bit_spacer;
  logic [WIDTH-1:0] bit_code;
  logic [WIDTH-1:0] bit_ill;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_rail
      // 00 = spacer, 01/10 = codeword, 11 = illegal
      assign bit_spacer[gi] = ~d_in[gi] & ~d_in_bar[gi];
      assign bit_code[gi]   =  d_in[gi] ^  d_in_bar[gi];
      assign bit_ill[gi]    =  d_in[gi] &  d_in_bar[gi];
    end
  endgenerate

  logic all_spacer;
  logic all_code;
  logic any_ill;

  assign all_spacer = &bit_spacer;
  assign all_code   = &bit_code;
  assign any_ill    = |bit_ill;

  assign timer_inc  = timer_q + 8'd1;

  // ---------------------------------------------------------------------
  // Capture values, one cone per share so the shares never meet
  // ---------------------------------------------------------------------
`ifdef LMDPL_DEC_REFRESH_EN
  assign s0_cap = m_in ^ r_fresh;
  assign s1_cap = d_in ^ r_fresh;
`else
  assign s0_cap = m_in;
  assign s1_cap = d_in;
`endif

  // Next-state, timer and capture/clear strobes for the decoder FSM
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    capture_en   = 1'b0;
    clear_shares = 1'b0;

    case (state_q)
      ST_PRE: begin
        // The previous word may still be draining: only a full spacer arms EVAL.
        timer_d = 8'd0;
        if (any_ill) begin
          state_d      = ST_ERR;
          clear_shares = 1'b1;
        end else if (all_spacer) begin
          state_d = ST_EVAL;
        end
      end

      ST_EVAL: begin
        // Illegal rails beat capture and timeout.
        if (any_ill) begin
          state_d      = ST_ERR;
          clear_shares = 1'b1;
          timer_d      = 8'd0;
        end else if (all_code) begin
          state_d    = ST_HOLD;
          capture_en = 1'b1;
          timer_d    = 8'd0;
        end else if (all_spacer) begin
          timer_d = 8'd0;
        end else if (timer_inc == TIMEOUT_L) begin
          // TIMEOUT consecutive partial cycles: the word will never complete.
          state_d      = ST_ERR;
          clear_shares = 1'b1;
          timer_d      = 8'd0;
        end else begin
          timer_d = timer_inc;
        end
      end

      ST_HOLD: begin
        // Inputs are ignored here; shares stay put until the consumer takes them.
        if (out_ready) begin
          state_d = ST_PRE;
        end
      end

      ST_ERR: begin
        if (err_clr) begin
          state_d = ST_PRE;
        end
      end

      default: begin
        state_d      = ST_PRE;
        timer_d      = 8'd0;
        clear_shares = 1'b1;
      end
    endcase
  end

  // Registered status flags derive from the next state so they align with it
  always_comb begin
    valid_d = (state_d == ST_HOLD);
    err_d   = (state_d == ST_ERR);
  end

  // Share 0 next value: cleared on error, loaded on capture, otherwise held
  always_comb begin
    s0_d = s0_q;
    if (clear_shares) begin
      s0_d = '0;
    end else if (capture_en) begin
      s0_d = s0_cap;
    end
  end

  // Share 1 next value: cleared on error, loaded on capture, otherwise held
  always_comb begin
    s1_d = s1_q;
    if (clear_shares) begin
      s1_d = '0;
    end else if (capture_en) begin
      s1_d = s1_cap;
    end
  end

  // FSM state, timer and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PRE;
      timer_q <= 8'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Share 0 register (kept apart from share 1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
    end else begin
      s0_q <= s0_d;
    end
  end

  // Share 1 register (kept apart from share 0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  assign out_s0    = s0_q;
  assign out_s1    = s1_q;
  assign out_valid = valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lmdpl_dual_rail_decoder_d1.sv
// Directed testbench for lmdpl_dual_rail_decoder_d1 (WIDTH=4, TIMEOUT=15).
// Each step drives inputs 1 time unit after a rising edge and samples the
// outputs 1 time unit after the next rising edge.
module tb_lmdpl_dual_rail_decoder_d1;

  logic       clk;
  logic       rst_n;
  logic [3:0] m_in;
  logic [3:0] d_in;
  logic [3:0] d_in_bar;
  logic [3:0] r_fresh;
  logic [3:0] out_s0;
  logic [3:0] out_s1;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic       err_clr;

  int n_checks;
  int n_pass;

  lmdpl_dual_rail_decoder_d1 #(
    .WIDTH   (4),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_in      (m_in),
    .d_in      (d_in),
    .d_in_bar  (d_in_bar),
`ifdef LMDPL_DEC_REFRESH_EN
    .r_fresh   (r_fresh),
`endif
    .out_s0    (out_s0),
    .out_s1    (out_s1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic e,
                           input logic [3:0] s0, input logic [3:0] s1);
    check_eq({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check_eq({tag, ".err"},   {31'd0, err},       {31'd0, e});
    check_eq({tag, ".s0"},    {28'd0, out_s0},    {28'd0, s0});
    check_eq({tag, ".s1"},    {28'd0, out_s1},    {28'd0, s1});
  endtask

  task automatic check_flags(input string tag, input logic v, input logic e);
    check_eq({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check_eq({tag, ".err"},   {31'd0, err},       {31'd0, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] m, input logic [3:0] d, input logic [3:0] db);
    m_in     = m;
    d_in     = d;
    d_in_bar = db;
  endtask

  task automatic spacer();
    drive(4'h0, 4'h0, 4'h0);
  endtask

  // Consume the held word with a one-cycle ready pulse
  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_flags(tag, 1'b0, 1'b0);
  endtask

  logic [3:0] exp_s0;
  logic [3:0] exp_s1;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    r_fresh   = 4'h0;
    spacer();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 1'b0, 4'h0, 4'h0);
    rst_n = 1'b1;

    // Case 1: basic word, with re-masking when the refresh port exists
    spacer();
    tick();
    check_out("t1.eval", 1'b0, 1'b0, 4'h0, 4'h0);
    drive(4'hA, 4'h6, 4'h9);
    r_fresh = 4'hF;
`ifdef LMDPL_DEC_REFRESH_EN
    exp_s0 = 4'h5;
    exp_s1 = 4'h9;
`else
    exp_s0 = 4'hA;
    exp_s1 = 4'h6;
`endif
    tick();
    r_fresh = 4'h0;
    check_out("t1.hold", 1'b1, 1'b0, exp_s0, exp_s1);
    $display("word t1: s0=%h s1=%h valid=%b", out_s0, out_s1, out_valid);
    consume("t1.consume");

    // Case 2: staggered rails, bit0 first, bits1-3 two cycles later
    spacer();
    tick();
    drive(4'h3, 4'h1, 4'h0);
    tick();
    check_flags("t2.partial1", 1'b0, 1'b0);
    tick();
    check_flags("t2.partial2", 1'b0, 1'b0);
    drive(4'h3, 4'h5, 4'hA);
    tick();
    check_out("t2.hold", 1'b1, 1'b0, 4'h3, 4'h5);
    $display("word t2: s0=%h s1=%h valid=%b", out_s0, out_s1, out_valid);
    consume("t2.consume");

    // Case 3: illegal rails on bit2 during EVAL, then recovery
    spacer();
    tick();
    drive(4'h0, 4'h4, 4'h4);
    tick();
    check_out("t3.err", 1'b0, 1'b1, 4'h0, 4'h0);
    spacer();
    tick();
    check_flags("t3.sticky", 1'b0, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_flags("t3.cleared", 1'b0, 1'b0);
    tick();
    drive(4'hC, 4'h9, 4'h6);
    tick();
    check_out("t3.hold", 1'b1, 1'b0, 4'hC, 4'h9);
    $display("word t3: s0=%h s1=%h valid=%b", out_s0, out_s1, out_valid);
    consume("t3.consume");

    // Case 4a: partial codeword held 15 cycles -> timeout error on the 15th
    spacer();
    tick();
    drive(4'hF, 4'h1, 4'h0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check_eq($sformatf("t4a.err_c%0d", i), {31'd0, err}, (i == 15) ? 32'd1 : 32'd0);
    end
    check_out("t4a.cleared_shares", 1'b0, 1'b1, 4'h0, 4'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_flags("t4a.clr", 1'b0, 1'b0);

    // Case 4b: same partial word for 14 cycles, then completed -> valid word
    spacer();
    tick();
    drive(4'hF, 4'h1, 4'h0);
    for (int i = 1; i <= 14; i++) begin
      tick();
      check_eq($sformatf("t4b.err_c%0d", i), {31'd0, err}, 32'd0);
    end
    drive(4'hF, 4'h1, 4'hE);
    tick();
    check_out("t4b.hold", 1'b1, 1'b0, 4'hF, 4'h1);
    $display("word t4b: s0=%h s1=%h valid=%b", out_s0, out_s1, out_valid);
    consume("t4b.consume");

    // Case 5: stalled consumer, inputs toggling (including illegal rails)
    spacer();
    tick();
    drive(4'h7, 4'hB, 4'h4);
    tick();
    check_out("t5.hold", 1'b1, 1'b0, 4'h7, 4'hB);
    for (int i = 0; i < 10; i++) begin
      drive(4'(i), 4'(i * 3), 4'(~i));
      r_fresh = 4'(i + 5);
      tick();
      check_out($sformatf("t5.stall%0d", i), 1'b1, 1'b0, 4'h7, 4'hB);
    end
    r_fresh = 4'h0;
    $display("word t5: s0=%h s1=%h valid=%b", out_s0, out_s1, out_valid);
    consume("t5.consume");

    // Case 6a: reset mid-EVAL clears held shares at once, PRE afterwards
    spacer();
    tick();
    drive(4'h1, 4'h1, 4'h0);
    tick();
    rst_n = 1'b0;
    #1;
    check_out("t6.rst_eval", 1'b0, 1'b0, 4'h0, 4'h0);
    #1;
    rst_n = 1'b1;
    tick();
    drive(4'h1, 4'h1, 4'hE);
    tick();
    check_flags("t6.pre_ignores", 1'b0, 1'b0);
    spacer();
    tick();
    drive(4'h9, 4'hC, 4'h3);
    tick();
    check_out("t6.hold", 1'b1, 1'b0, 4'h9, 4'hC);
    $display("word t6: s0=%h s1=%h valid=%b", out_s0, out_s1, out_valid);

    // Case 6b: reset mid-HOLD
    rst_n = 1'b0;
    #1;
    check_out("t6.rst_hold", 1'b0, 1'b0, 4'h0, 4'h0);
    #1;
    rst_n = 1'b1;
    tick();
    check_out("t6.after_rst", 1'b0, 1'b0, 4'h0, 4'h0);

    // Back-to-back words at the 3-cycle minimum period, ready tied high
    out_ready = 1'b1;
    spacer();
    tick();
    drive(4'h5, 4'h3, 4'hC);
    tick();
    check_out("t7.word1", 1'b1, 1'b0, 4'h5, 4'h3);
    $display("word t7a: s0=%h s1=%h valid=%b", out_s0, out_s1, out_valid);
    spacer();
    tick();
    check_flags("t7.pre", 1'b0, 1'b0);
    tick();
    drive(4'hE, 4'h8, 4'h7);
    tick();
    check_out("t7.word2", 1'b1, 1'b0, 4'hE, 4'h8);
    $display("word t7b: s0=%h s1=%h valid=%b", out_s0, out_s1, out_valid);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
